// File: rtl/jk_excitation_driver_pkg.sv
// Shared types and the per-bit JK excitation rule for jk_excitation_driver.
// Optional build macro JK_TOGGLE_EN selects toggle drive (J=K=1) for changing bits.
package jk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // {J,K} pairs; don't-care entries of the excitation table resolve to 0.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  function automatic logic [1:0] jk_excite(input logic cur, input logic tgt);
`ifdef JK_TOGGLE_EN
    return (cur != tgt) ? JK_TOGGLE : JK_HOLD;
`else
    case ({cur, tgt})
      2'b01:   return JK_SET;
      2'b10:   return JK_RESET;
      default: return JK_HOLD;
    endcase
`endif
  endfunction

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Target handshake, bank feedback and bank drive for jk_excitation_driver.
// Handshake: a target transfers on a rising edge where Tgt_valid && Tgt_ready.
interface jk_excitation_driver_if
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic             Tgt_valid;
  logic             Tgt_ready;
  logic [WIDTH-1:0] Tgt_data;
  logic [WIDTH-1:0] Q_fb;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             Busy;
  logic             Done;
  logic             Err;
  state_e           dbg_state;

  modport master (
    output Tgt_valid, Tgt_data, Q_fb,
    input  Tgt_ready, J, K, Busy, Done, Err, dbg_state
  );

  modport slave (
    input  Tgt_valid, Tgt_data, Q_fb,
    output Tgt_ready, J, K, Busy, Done, Err, dbg_state
  );
endinterface

// File: rtl/jk_excite_lut.sv
// Combinational WIDTH-wide excitation lookup: (cur, tgt) -> (J, K) per bit.
// Follows JK_TOGGLE_EN through jk_pkg::jk_excite.
module jk_excite_lut
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = jk_excite(cur[i], tgt[i]);
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flip-flop bank to a requested state and watches Q feedback for Done/Err.
// Build option JK_TOGGLE_EN (in jk_pkg) switches changing bits to toggle drive.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  jk_excitation_driver_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] tgt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] lut_j, lut_k;
  logic [WIDTH-1:0] j_q, k_q;
  logic             busy_q, done_q, err_q;
  logic             accept;

  assign accept = (state == IDLE) && bus.Tgt_valid;

  // The snapshot of Q_fb taken at accept is exactly what the LUT sees on that
  // edge, so the drive is registered then and is valid throughout DRIVE.
  jk_excite_lut #(.WIDTH(WIDTH)) u_lut (
    .cur (bus.Q_fb),
    .tgt (bus.Tgt_data),
    .j   (lut_j),
    .k   (lut_k)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   state_nxt = WAIT;
      WAIT: begin
        if (bus.Q_fb == tgt)                   state_nxt = DONE;
        else if (cnt == CW'(TIMEOUT - 1))      state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= IDLE;
      tgt    <= '0;
      cnt    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) tgt <= bus.Tgt_data;
      if (state == DRIVE)
        cnt <= '0;
      else if (state == WAIT && state_nxt == WAIT)
        cnt <= cnt + CW'(1);
      // Outputs are registered against the next state so they line up with it.
      j_q    <= (state_nxt == DRIVE) ? lut_j : '0;
      k_q    <= (state_nxt == DRIVE) ? lut_k : '0;
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
      err_q  <= (state_nxt == ERR);
    end
  end

  assign bus.Tgt_ready = (state == IDLE);
  assign bus.J         = j_q;
  assign bus.K         = k_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Err       = err_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Inverse of a JK flip-flop. A flip-flop maps (J,K) to next Q; this block maps (current Q, target Q) to the (J,K) drive needed to reach the target.
- Accepts a target state word over a valid/ready handshake and drives a bank of WIDTH JK flip-flops for one cycle.
- Watches the bank's Q feedback until it matches the target, then reports Done or Err.
- Sits between a sequence controller and a JK register bank; used as the stimulus driver in flip-flop counter/sequencer designs.

Parameters:
- WIDTH, 4, number of JK flip-flops driven (>=1).
- TIMEOUT, 4, maximum WAIT cycles allowed for Q_fb to match the target (>=1).

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Rst_n  input  1  synchronous, active-low reset, sampled on rising Clk.
- Tgt_valid  input  1  target word offered.
- Tgt_ready  output  1  block can accept a target.
- Tgt_data  input  WIDTH  desired next flip-flop state.
- Q_fb  input  WIDTH  Q outputs of the driven flip-flop bank.
- J  output  WIDTH  J drive to the bank.
- K  output  WIDTH  K drive to the bank.
- Busy  output  1  high in any state other than IDLE.
- Done  output  1  one-cycle pulse: target reached.
- Err  output  1  one-cycle pulse: timeout without match.

Behaviour:
- Reset (Rst_n=0 at a rising edge):
  - state=IDLE, J=0, K=0, Done=0, Err=0, Busy=0, Tgt_ready=1.
  - Internal target, snapshot and counter cleared.
  - Reset mid-operation aborts immediately; no Done/Err is issued for the aborted target.
- States and outputs:
  - IDLE: Tgt_ready=1, J=K=0. On Tgt_valid&&Tgt_ready at an edge, register tgt=Tgt_data and cur=Q_fb, then go to DRIVE.
  - DRIVE: exactly one cycle. J/K driven from the excitation table on (cur,tgt). Go to WAIT; counter=0.
  - WAIT: J=K=0.
    - If Q_fb==tgt, go to DONE.
    - Else if counter==TIMEOUT-1, go to ERR.
    - Else counter+1.
  - DONE: Done=1 for one cycle, then IDLE.
  - ERR: Err=1 for one cycle, then IDLE.
- Handshake:
  - Tgt_ready is high only in IDLE.
  - Tgt_valid is ignored in every other state; no buffering.
  - Back-to-back targets have a minimum 4-cycle spacing (IDLE, DRIVE, WAIT, DONE).
- Excitation table, per bit (cur -> tgt : J,K):
  - 0 -> 0 : 0,0
  - 0 -> 1 : 1,0
  - 1 -> 0 : 0,1
  - 1 -> 1 : 0,0
  - Don't-care terms are resolved to 0.
- Latency with an ideal posedge flip-flop bank:
  - Accept at edge 0, DRIVE in cycle 1, WAIT in cycle 2 sees the updated Q_fb, Done high in cycle 3.
- Target equal to the current state: DRIVE issues J=K=0 and Done follows on the same schedule.
- Counter width is $clog2(TIMEOUT+1); no wrap is possible.
- J, K, Done, Err and Busy are registered. Tgt_ready is decoded from the state register.

Optional Feature:
- Macro: JK_TOGGLE_EN.
- Defined: every bit where cur!=tgt is driven J=1,K=1 (toggle) in DRIVE; bits with cur==tgt are driven 0,0. The final state is identical; this exercises the toggle path of the bank.
- Undefined: the set/reset encoding from the excitation table above. J&K is never 1 on any bit.

Decomposition:
- Package jk_pkg holds:
  - State enum: IDLE, DRIVE, WAIT, DONE, ERR.
  - Per-bit excitation constants.
  - Function jk_excite(cur, tgt) returning {J,K}.
- Sub-module jk_excite_lut (combinational, WIDTH-wide, honours JK_TOGGLE_EN). It is instantiated once; its outputs are registered in DRIVE.
- The FSM, counter and handshake live in the top module.

Test Plan:
- Bench setup: WIDTH=4, TIMEOUT=4, ideal JK bank model reset to 0000.
- Reset: hold Rst_n=0 for 2 cycles -> J=K=0000, Busy=0, Tgt_ready=1, Done=Err=0.
- Basic move: Q=0000, offer Tgt_data=1010 -> DRIVE cycle shows J=1010, K=0000. Done pulses 3 cycles after accept; Q_fb=1010.
- Mixed move: Q=1010, target 0110 -> J=0100, K=1000 (with JK_TOGGLE_EN: J=K=1100). Done follows; Q_fb=0110.
- No-op target: Q=0110, target 0110 -> J=K=0000 in DRIVE; Done on the standard schedule.
- Timeout: bank model stuck (ignores J/K), target 1111 -> exactly 4 WAIT cycles, then a one-cycle Err pulse, Done never asserted. Tgt_valid held during Busy is not accepted.
- Reset mid-op: assert Rst_n=0 during WAIT -> next cycle state IDLE, J=K=0, no Done/Err pulse. A new target is accepted normally afterwards.
